uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

Byte-buffered 8N1 UART transmitter. Accepts parallel bytes through a valid/ready handshake into a small synchronous FIFO and serialises them onto a single line at `CLKS_PER_BIT` clocks per bit. It sits upstream of the serial line consumed by `serial_transceiver`'s `din`, and drives frames in the same format that block receives: start 0, 8 data bits LSB first, stop 1, idle high.

## Interface

- `CLKS_PER_BIT`, 10416, clocks per serial bit (100 MHz / 9600 baud); legal range 2..65535.
- `FIFO_DEPTH`, 8, byte buffer depth; power of two, 2..64.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `tx_data`  in  8  byte to send.
- `tx_valid`  in  1  `tx_data` is offered this cycle.
- `tx_ready`  out  1  FIFO can accept this cycle; equals `count != FIFO_DEPTH`.
- `dout`  out  1  serial line; registered output.
- `busy`  out  1  a frame is in progress or the FIFO is non-empty.
- `count`  out  $clog2(FIFO_DEPTH)+1  bytes currently held in the FIFO.

## Operation

- Push: `tx_valid && tx_ready` at a rising edge writes `tx_data`. Offers while `tx_ready=0` are ignored and the byte is lost. The block never stalls the producer silently.
- Pop: the FSM takes the FIFO head when in IDLE, or at the end of STOP, if `count != 0`.
- Push and pop on the same edge: `count` is unchanged. When full, `tx_ready` is 0, so no push occurs even if a pop happens that cycle.
- FSM states and `dout` values:
  - IDLE: `dout`=1.
  - START: `dout`=0.
  - DATA: `dout`=`shreg[0]`; shift right once per bit; 8 bits.
  - STOP: `dout`=1.
- Transitions:
  - IDLE→START on pop.
  - START→DATA after one bit period.
  - DATA→STOP after 8 bit periods.
  - STOP→START if the FIFO is non-empty (pop on that edge). Otherwise STOP→IDLE.
- Counters:
  - Bit-period counter runs 0..CLKS_PER_BIT-1 and wraps. State advances on the wrap.
  - Bit index runs 0..7.
- Every bit is held exactly `CLKS_PER_BIT` cycles. A frame is exactly `10*CLKS_PER_BIT` cycles. Back-to-back frames have zero idle gap.
- Reset values: `dout`=1, `tx_ready`=1, `busy`=0, `count`=0, FSM in IDLE, pointers and counters 0.
- Reset mid-frame: on the reset edge `dout` returns to 1, FIFO contents are discarded, and the partial frame is abandoned with no stop bit.

## Timing

- Latency: byte accepted at edge k while IDLE with an empty FIFO → `dout` falls at edge k+1 (FIFO write at k, pop/load at k+1).
- `tx_ready` and `count` reflect state after the current edge, so there are no combinational paths from `tx_valid`.
- `busy` rises at the push edge and falls at the edge where STOP ends with an empty FIFO.
- Pointer wrap: write and read pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full/empty are decided by `count`, not by pointer compare.

## Structure

- Shared package `uart_pkg`:
  - `UART_DATA_BITS`=8.
  - `UART_FRAME_BITS`=10.
  - Default `CLKS_PER_BIT`=10416.
  - FSM state enum {IDLE, START, DATA, STOP}.
- One sub-module, `sync_fifo` (parameterised width/depth, push/pop/count, registered read data with first-word fall-through). This module is reusable later on the receive side.
- The top level holds the FSM, bit-period counter, bit index and shift register.

## Test plan

- Single byte, `CLKS_PER_BIT`=4: push 0x63 → `dout` reads 0,1,1,0,0,0,1,1,0,1 (each held 4 cycles), starting one edge after the push. `busy` falls after 40 cycles.
- Back-to-back, `CLKS_PER_BIT`=4: push 0x63 then 0x8E in consecutive cycles → 20 bit-periods. The second start bit directly follows the first stop, and the second frame reads 0,0,1,1,1,0,0,0,1,1.
- Full FIFO, `FIFO_DEPTH`=8, `CLKS_PER_BIT`=4: push 0x00..0x09 every cycle → `tx_ready` drops when `count`=8. Exactly 9 bytes go out in order (one is popped immediately) and the dropped byte never appears.
- Simultaneous push/pop at full: hold `tx_valid` high → `count` stays at 7 or 8 and never exceeds `FIFO_DEPTH`. No duplicated or skipped bytes.
- Reset mid-frame: assert `rst` during DATA bit 3 of 0x55 → `dout`=1 the next edge, `count`=0, `busy`=0. Push 0xA5 afterwards → a clean frame.
- Default parameters: push 0x63 → each bit measured at exactly 10416 cycles. This matches the 20832-time-unit bit spacing of a 2-unit clock.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default bit timing and transmitter FSM states.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS    = 8;
    localparam int unsigned UART_FRAME_BITS   = 10;
    localparam int unsigned UART_CLKS_PER_BIT = 10416;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through read from registered storage.
// Full/empty come from the occupancy counter; pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok, pop_ok;

    always_comb begin
        push_ok  = push && !full_q;
        pop_ok   = pop && !empty_q;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage is not reset; contents are only visible through a non-zero count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Byte-buffered 8N1 UART transmitter: valid/ready byte input into a FIFO,
// serialised LSB first with start/stop bits and zero gap between queued frames.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned  CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned  FIFO_DEPTH   = 8,
    localparam int unsigned CW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic          dout,
    output logic          busy,
    output logic [CW-1:0] count
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             dout_q, dout_d;
    logic             busy_q, busy_d;

    logic             pop_c;
    logic             push_c;
    logic             bit_end;
    logic [7:0]       fifo_rd_data;
    logic [CW-1:0]    fifo_count;
    logic [CW-1:0]    fifo_count_nxt;
    logic             fifo_full;
    logic             fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (tx_valid),
        .wr_data (tx_data),
        .pop     (pop_c),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Next-state: bit timing, frame sequencing and FIFO pops.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        dout_d    = dout_q;
        pop_c     = 1'b0;
        bit_end   = (cnt_q == LAST_CNT);

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    shreg_d = fifo_rd_data;
                    cnt_d   = '0;
                    state_d = START;
                    dout_d  = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    dout_d    = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                        dout_d  = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                        shreg_d   = shreg_q >> 1;
                        dout_d    = shreg_q[1];
                    end
                end
            end
            STOP: begin
                // Chain straight into the next start bit when more bytes are queued.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop_c   = 1'b1;
                        shreg_d = fifo_rd_data;
                        state_d = START;
                        dout_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                        dout_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                dout_d  = 1'b1;
            end
        endcase

        push_c         = tx_valid && !fifo_full;
        fifo_count_nxt = fifo_count + CW'(push_c) - CW'(pop_c);
        busy_d         = (state_d != IDLE) || (fifo_count_nxt != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            dout_q    <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            dout_q    <= dout_d;
            busy_q    <= busy_d;
        end
    end

    assign tx_ready = !fifo_full;
    assign count    = fifo_count;
    assign dout     = dout_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: frame-timeline reference model, line decoder and scenario tasks.
module tb_uart_tx_buffered;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned FRAME = 10 * CPB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4 = 1'b1, v4 = 1'b0;
    logic [7:0] d4 = 8'h00;
    logic       ready4, dout4, busy4;
    logic [3:0] count4;

    logic       rstd = 1'b1, vd = 1'b0;
    logic [7:0] dd = 8'h00;
    logic       readyd, doutd, busyd;
    logic [3:0] countd;

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst4), .tx_data(d4), .tx_valid(v4),
        .tx_ready(ready4), .dout(dout4), .busy(busy4), .count(count4)
    );

    uart_tx_buffered dut_def (
        .clk(clk), .rst(rstd), .tx_data(dd), .tx_valid(vd),
        .tx_ready(readyd), .dout(doutd), .busy(busyd), .count(countd)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: byte queue plus remaining cycles of the frame on the line.
    logic [7:0] mq[$];
    logic [7:0] acc_q[$];
    logic [7:0] rx_q[$];
    int         rem = 0;
    logic [7:0] cur = 8'h00;
    logic       m_dout = 1'b1, m_busy = 1'b0, m_ready = 1'b1;
    int         m_count = 0;

    function automatic logic frame_bit(input logic [7:0] b, input int pos);
        int idx;
        idx = pos / CPB;
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    task automatic model_edge(input logic v, input logic [7:0] d, input logic r);
        int  sz;
        bit  do_push;
        if (r) begin
            mq.delete();
            rem = 0;
        end else begin
            sz      = mq.size();
            do_push = v && (sz < DEPTH);
            if (rem > 0) rem--;
            if (rem == 0 && sz > 0) begin
                cur = mq.pop_front();
                rem = FRAME;
            end
            if (do_push) begin
                mq.push_back(d);
                acc_q.push_back(d);
            end
        end
        m_count = mq.size();
        m_busy  = (rem > 0) || (m_count > 0);
        m_ready = (m_count != DEPTH);
        m_dout  = (rem > 0) ? frame_bit(cur, FRAME - rem) : 1'b1;
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic r);
        v4   = v;
        d4   = d;
        rst4 = r;
        model_edge(v, d, r);
        @(posedge clk);
        #1;
    endtask

    // Line decoder: samples mid-bit, checks the stop bit, collects bytes.
    int         mon_pos = -1;
    logic [7:0] mon_byte = 8'h00;
    initial begin
        forever begin
            @(negedge clk);
            if (rst4 !== 1'b0) begin
                mon_pos = -1;
            end else if (mon_pos < 0) begin
                if (dout4 === 1'b0) begin
                    mon_pos  = 0;
                    mon_byte = 8'h00;
                end
            end else begin
                mon_pos++;
                if ((mon_pos % CPB) == CPB / 2 && mon_pos / CPB >= 1 && mon_pos / CPB <= 8)
                    mon_byte[mon_pos / CPB - 1] = dout4;
                if (mon_pos == 9 * CPB + CPB / 2) begin
                    checks++;
                    if (dout4 !== 1'b1) begin
                        failures++;
                        $display("FAIL stop_bit got=%b exp=1 byte=%h", dout4, mon_byte);
                    end
                    rx_q.push_back(mon_byte);
                end
                if (mon_pos == FRAME - 1) mon_pos = -1;
            end
        end
    end

    task automatic test_reset();
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hFF, 1'b1);
        checks++;
        if ({dout4, ready4, busy4, count4} !== 7'b1100000) begin
            failures++;
            $display("FAIL reset_state got=%b exp=1100000", {dout4, ready4, busy4, count4});
        end
        checks++;
        if ({doutd, readyd, busyd, countd} !== 7'b1100000) begin
            failures++;
            $display("FAIL reset_state_def got=%b exp=1100000", {doutd, readyd, busyd, countd});
        end
        rstd = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        acc_q.delete();
        rx_q.delete();
    endtask

    task automatic test_single();
        logic [9:0] pat;
        pat = 10'b1011000110;
        step(1'b1, 8'h63, 1'b0);
        checks++;
        if ({dout4, busy4, count4} !== 6'b110001) begin
            failures++;
            $display("FAIL single_push got=%b exp=110001", {dout4, busy4, count4});
        end
        for (int i = 0; i < FRAME; i++) begin
            step(1'b0, 8'h00, 1'b0);
            checks++;
            if (dout4 !== pat[i / CPB] || busy4 !== 1'b1) begin
                failures++;
                $display("FAIL single_bit cyc=%0d got=%b%b exp=%b1", i, dout4, busy4, pat[i / CPB]);
            end
        end
        step(1'b0, 8'h00, 1'b0);
        checks++;
        if ({busy4, dout4, count4} !== 6'b010000) begin
            failures++;
            $display("FAIL single_end got=%b exp=010000", {busy4, dout4, count4});
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] pat1, pat2;
        logic       rec[81];
        pat1 = 10'b1011000110;
        pat2 = 10'b1100011100;
        step(1'b1, 8'h63, 1'b0);
        step(1'b1, 8'h8E, 1'b0);
        rec[0] = dout4;
        for (int i = 1; i <= 2 * FRAME; i++) begin
            step(1'b0, 8'h00, 1'b0);
            rec[i] = dout4;
            checks++;
            if ({dout4, busy4, ready4, count4} !== {m_dout, m_busy, m_ready, 4'(m_count)}) begin
                failures++;
                $display("FAIL b2b_model cyc=%0d got=%b exp=%b", i,
                         {dout4, busy4, ready4, count4}, {m_dout, m_busy, m_ready, 4'(m_count)});
            end
        end
        for (int i = 0; i < FRAME; i++) begin
            checks++;
            if (rec[i] !== pat1[i / CPB] || rec[FRAME + i] !== pat2[i / CPB]) begin
                failures++;
                $display("FAIL b2b_bits cyc=%0d got=%b%b exp=%b%b", i, rec[i], rec[FRAME + i],
                         pat1[i / CPB], pat2[i / CPB]);
            end
        end
        checks++;
        if (busy4 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_busy_end got=%b exp=0", busy4);
        end
    endtask

    task automatic test_full();
        rx_q.delete();
        acc_q.delete();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(i), 1'b0);
            if (i == 8) begin
                checks++;
                if ({ready4, count4} !== 5'b01000) begin
                    failures++;
                    $display("FAIL full_ready got=%b exp=01000", {ready4, count4});
                end
            end
        end
        for (int i = 0; i < 9 * FRAME + 10; i++) step(1'b0, 8'h00, 1'b0);
        checks++;
        if (rx_q.size() != 9 || busy4 !== 1'b0) begin
            failures++;
            $display("FAIL full_count got=%0d/%b exp=9/0", rx_q.size(), busy4);
        end
        for (int i = 0; i < rx_q.size() && i < 9; i++) begin
            checks++;
            if (rx_q[i] !== 8'(i)) begin
                failures++;
                $display("FAIL full_order idx=%0d got=%h exp=%h", i, rx_q[i], 8'(i));
            end
        end
    endtask

    task automatic run_compare(input string name, input int n, input int mode);
        logic v;
        for (int i = 0; i < n; i++) begin
            v = (mode == 0) ? 1'b1 : ($urandom_range(0, 5) < 2);
            step(v, 8'($urandom), 1'b0);
            checks++;
            if ({dout4, busy4, ready4, count4} !== {m_dout, m_busy, m_ready, 4'(m_count)}) begin
                failures++;
                $display("FAIL %s_model cyc=%0d got=%b exp=%b", name, i,
                         {dout4, busy4, ready4, count4}, {m_dout, m_busy, m_ready, 4'(m_count)});
            end
            if (mode == 0 && i > 20) begin
                checks++;
                if (count4 < 4'd7 || count4 > 4'd8) begin
                    failures++;
                    $display("FAIL hold_count cyc=%0d got=%0d exp=7..8", i, count4);
                end
            end
        end
        for (int i = 0; i < 9 * FRAME + 10; i++) step(1'b0, 8'h00, 1'b0);
        checks++;
        if (rx_q.size() != acc_q.size() || busy4 !== 1'b0) begin
            failures++;
            $display("FAIL %s_bytes got=%0d/%b exp=%0d/0", name, rx_q.size(), busy4, acc_q.size());
        end
        for (int i = 0; i < rx_q.size() && i < acc_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== acc_q[i]) begin
                failures++;
                $display("FAIL %s_order idx=%0d got=%h exp=%h", name, i, rx_q[i], acc_q[i]);
            end
        end
    endtask

    task automatic test_hold_full();
        rx_q.delete();
        acc_q.delete();
        run_compare("hold", 300, 0);
    endtask

    task automatic test_random();
        rx_q.delete();
        acc_q.delete();
        run_compare("rand", 800, 1);
    endtask

    task automatic test_reset_mid();
        rx_q.delete();
        acc_q.delete();
        step(1'b1, 8'h55, 1'b0);
        for (int i = 0; i < 18; i++) step(1'b1, 8'h77, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if ({dout4, ready4, busy4, count4} !== 7'b1100000) begin
            failures++;
            $display("FAIL reset_mid got=%b exp=1100000", {dout4, ready4, busy4, count4});
        end
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < FRAME + 10; i++) step(1'b0, 8'h00, 1'b0);
        checks++;
        if (rx_q.size() != 1 || (rx_q.size() == 1 && rx_q[0] !== 8'hA5)) begin
            failures++;
            $display("FAIL reset_mid_frame got=%0d bytes first=%h exp=1 A5", rx_q.size(),
                     (rx_q.size() > 0) ? rx_q[0] : 8'h00);
        end
    endtask

    task automatic test_default();
        int n;
        vd = 1'b1;
        dd = 8'h63;
        @(posedge clk);
        #1;
        vd = 1'b0;
        checks++;
        if ({doutd, busyd} !== 2'b11) begin
            failures++;
            $display("FAIL def_push got=%b exp=11", {doutd, busyd});
        end
        @(posedge clk);
        #1;
        checks++;
        if (doutd !== 1'b0) begin
            failures++;
            $display("FAIL def_latency got=%b exp=0", doutd);
        end
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (doutd === 1'b0 && n < 30000);
        checks++;
        if (n != 10416) begin
            failures++;
            $display("FAIL def_start_bit got=%0d exp=10416", n);
        end
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (doutd === 1'b1 && n < 30000);
        checks++;
        if (n != 2 * 10416) begin
            failures++;
            $display("FAIL def_data_bits got=%0d exp=20832", n);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_hold_full();
        test_random();
        test_reset_mid();
        test_default();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
